// File: rtl/afifo_wr_arb.sv
// Write-side arbiter for the async FIFO: round-robin sharing of the single write port
// among NREQ wclk-domain requesters, each grant bounded to BURST beats.
module afifo_wr_arb #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [IDW-1:0]          gnt_id,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(BURST) + 1;

  typedef enum logic {StIdle, StXfer} state_e;

  state_e           r_state, w_state_nxt;
  logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0]   r_last, w_last_nxt;
  logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;

  logic [IDW-1:0]   w_pick;
  logic             w_pick_found;
  logic             w_sel_valid;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_winc;

  // Round-robin search starting just above the previous owner, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    w_pick       = '0;
    w_pick_found = 1'b0;
    idx          = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(r_last) + k) % NREQ;
      if (!w_pick_found && req_valid[IDW'(idx)]) begin
        w_pick_found = 1'b1;
        w_pick       = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gnt_id == IDW'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    w_winc         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_gnt_id_nxt   = w_pick;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = StXfer;
        end
      end
      StXfer: begin
        w_winc = w_sel_valid & ~wfull;
        if (!w_sel_valid) begin
          // Owner withdrew: release without counting a beat.
          w_last_nxt  = r_gnt_id;
          w_state_nxt = StIdle;
        end else if (w_winc) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          if (r_beat_cnt == CW'(BURST - 1)) begin
            w_last_nxt  = r_gnt_id;
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= StIdle;
      r_gnt_id   <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = w_winc && (r_gnt_id == IDW'(i));
    end
  end

  assign winc   = w_winc;
  assign wdata  = w_sel_data;
  assign gnt_id = r_gnt_id;
  assign busy   = (r_state == StXfer);

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: directed scenarios plus random traffic, all checked against
// a transaction-level model of owner / beats-granted / last-owner.
module tb_afifo_wr_arb;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;

  afifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST), .IDW(IDW)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: owner -1 means nobody holds the port.
  int m_owner, m_beats, m_last;

  int              obs_winc;
  logic            prev_busy;
  logic [NREQ-1:0] acc;
  logic [15:0]     pat;
  int              gnt_log[$];
  int              n_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int i);
    return ((req_valid >> i) & 4'd1) != 4'd0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NREQ - 1;
  endtask

  task automatic model_step();
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!found && vld(c)) begin
          found   = 1'b1;
          m_owner = c;
          m_beats = 0;
        end
      end
    end else if (!vld(m_owner)) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (!wfull) begin
      m_beats++;
      if (m_beats == BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic check_model();
    logic e_busy, e_winc;
    e_busy = (m_owner >= 0);
    e_winc = e_busy && vld(m_owner) && !wfull;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("winc", 64'(winc), 64'(e_winc));
    chk("req_ready", 64'(req_ready), e_winc ? (64'd1 << m_owner) : 64'd0);
    if (e_busy) chk("gnt_id", 64'(gnt_id), 64'(m_owner));
    if (e_winc) chk("wdata", 64'(wdata), 64'(req_data >> (m_owner * DSIZE)) & 64'hFF);
  endtask

  // Inputs are set at the falling edge; sample 1ns later, then advance one clock.
  task automatic cycle();
    #1;
    check_model();
    obs_winc += int'(winc);
    pat = {pat[14:0], winc};
    if (busy && !prev_busy) gnt_log.push_back(int'(gnt_id));
    prev_busy = busy;
    acc = req_ready;
    model_step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  // Data may change only when the lane is idle or its beat was just accepted.
  task automatic upd_data();
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || acc[i]) req_data[i*DSIZE +: DSIZE] = 8'($urandom);
    end
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    wfull     = 1'b0;
    acc       = '0;
    prev_busy = 1'b0;
    pat       = '0;
    obs_winc  = 0;
    n_acc     = 0;
    model_reset();

    // T1: reset holds everything quiet even with all requests up.
    @(negedge wclk);
    @(negedge wclk);
    #1;
    chk("t1_winc", 64'(winc), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_ready", 64'(req_ready), 64'd0);
    chk("t1_gnt", 64'(gnt_id), 64'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // T2: all four requesting; grants 0,1,2,3,0 and 16 beats in the first 20 cycles.
    obs_winc = 0;
    for (int c = 0; c < 22; c++) begin
      upd_data();
      if (c == 20) chk("t2_beats_in_20", 64'(obs_winc), 64'd16);
      cycle();
    end
    chk("t2_ngrants", 64'(gnt_log.size()), 64'd5);
    for (int g = 0; g < 5 && g < gnt_log.size(); g++) chk("t2_order", 64'(gnt_log[g]), 64'(g % 4));
    // Let req 0's burst finish, then go quiet.
    for (int c = 0; c < 3; c++) begin upd_data(); cycle(); end
    req_valid = '0;
    for (int c = 0; c < 3; c++) cycle();
    #1 chk("idle_busy", 64'(busy), 64'd0);

    // T3: req 2 stalls on wfull for 3 cycles after its first beat.
    obs_winc = 0;
    req_valid = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      upd_data();
      wfull = (c >= 3 && c <= 5);
      if (c >= 3 && c <= 5) begin
        #1;
        chk("t3_stall_winc", 64'(winc), 64'd0);
        chk("t3_stall_gnt", 64'(gnt_id), 64'd2);
      end
      cycle();
    end
    wfull = 1'b0;
    chk("t3_beats", 64'(obs_winc), 64'd4);
    req_valid = '0;
    cycle();

    // T4: req 1 withdraws after two beats; next owner is lowest set index above 1.
    req_valid = 4'b0010;
    for (int c = 1; c <= 3; c++) begin upd_data(); cycle(); end
    req_valid = 4'b1001;
    upd_data();
    #1 chk("t4_drop_winc", 64'(winc), 64'd0);
    cycle();
    #1 chk("t4_bubble", 64'(busy), 64'd0);
    cycle();
    #1 chk("t4_next_gnt", 64'(gnt_id), 64'd3);
    req_valid = '0;
    cycle();
    cycle();

    // T5: only req 3, ten beats with a known data sequence.
    pat   = '0;
    n_acc = 0;
    acc   = '0;
    for (int c = 1; c <= 16; c++) begin
      req_valid = (n_acc < 10) ? 4'b1000 : 4'b0000;
      req_data[3*DSIZE +: DSIZE] = 8'hA0 + 8'(n_acc);
      cycle();
      if (acc[3]) n_acc++;
    end
    chk("t5_pattern", 64'(pat), 64'h7BD8);
    chk("t5_nbeats", 64'(n_acc), 64'd10);

    // T6: reset asserted during req 2's second beat.
    req_valid = 4'b0100;
    for (int c = 1; c <= 2; c++) begin upd_data(); cycle(); end
    #1 chk("t6_pre_winc", 64'(winc), 64'd1);
    wrst_n = 1'b0;
    #1;
    chk("t6_winc", 64'(winc), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd0);
    chk("t6_gnt", 64'(gnt_id), 64'd0);
    model_reset();
    prev_busy = 1'b0;
    acc = '0;
    @(posedge wclk);
    @(negedge wclk);
    wrst_n    = 1'b1;
    req_valid = 4'b1111;
    cycle();
    #1 chk("t6_first_gnt", 64'(gnt_id), 64'd0);

    // Random traffic with valid/data held until accepted and random backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !acc[i])) req_valid[i] = ($urandom_range(0, 3) != 0);
      end
      upd_data();
      wfull = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
